cdb_multi: RTL
==============

Name: cdb_multi

Overview:
- Parametrised, multi-lane common data bus.
- Arbitrates NUM_SRC execution-unit completion requests onto NUM_CDB registered broadcast lanes per cycle.
- Uses round-robin (or fixed) priority with a valid/ready handshake, so losing units hold their results.
- Sits between the functional units and the RS/PRF/ROB wakeup and completion logic, and supports squash on branch recovery.

Parameters:
- NUM_SRC, 4: number of requesting units; index 0 is the highest fixed priority.
- NUM_CDB, 2: number of broadcast lanes; 1 <= NUM_CDB <= NUM_SRC.
- XLEN, 32: value and PC width.
- PRF_LEN, 6: physical-register index width.
- ROB_LEN, 5: ROB index width.
- RR_EN, 1: 1 = round-robin priority, 0 = fixed priority (source 0 highest).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  mispredict recovery: kill this cycle's grants and clear lanes.
- src_valid  in  NUM_SRC  per-source completion request.
- src_wb  in  NUM_SRC  1 = result writes the PRF; 0 = completion only (branch/store).
- src_value  in  NUM_SRC*XLEN  packed results; source i occupies [i*XLEN +: XLEN].
- src_prf_idx  in  NUM_SRC*PRF_LEN  packed destination pregs.
- src_rob_idx  in  NUM_SRC*ROB_LEN  packed ROB indices.
- src_PC  in  NUM_SRC*XLEN  packed instruction PCs.
- src_ready  out  NUM_SRC  combinational grant; source i is consumed this cycle.
- cdb_valid  out  NUM_CDB  lane carries a completion (ROB update).
- cdb_wb_valid  out  NUM_CDB  lane also writes the PRF and wakes the RS.
- cdb_value  out  NUM_CDB*XLEN  lane values.
- cdb_prf_idx  out  NUM_CDB*PRF_LEN  lane destination pregs.
- cdb_rob_idx  out  NUM_CDB*ROB_LEN  lane ROB indices.
- cdb_PC  out  NUM_CDB*XLEN  lane PCs.
- cdb_src_sel  out  NUM_CDB*NUM_SRC  registered one-hot source id per lane (debug/perf).

Behaviour:
- Reset: all registered outputs are 0 (cdb_valid, cdb_wb_valid, value, idx, PC, src_sel). Round-robin pointer ptr = 0.
- Handshake:
  - src_ready[i] = src_valid[i] & granted[i] & ~squash, purely combinational.
  - A source holds valid and payload stable until it sees ready high at a clock edge.
  - src_ready never asserts without src_valid.
- Arbitration (combinational, each cycle):
  - Scan sources in order ptr, ptr+1, ... mod NUM_SRC.
  - The first NUM_CDB requesters are granted, in scan order.
  - The k-th granted source drives lane k; lanes fill from 0 upward with no gaps.
- Latency: a source granted in cycle t appears on its lane in cycle t+1 (one register stage). Unused lanes have cdb_valid=0 and zero payload.
- cdb_wb_valid[k] = cdb_valid[k] & src_wb of the granted source.
- Pointer update (RR_EN=1):
  - If any grant and no squash: ptr <= (index of the last granted source + 1) mod NUM_SRC.
  - Otherwise ptr holds.
  - With RR_EN=0, ptr is constant 0.
- Fairness: with RR_EN=1, a continuously requesting source is granted within ceil(NUM_SRC/NUM_CDB) cycles.
- Squash: no src_ready asserts that cycle, all lanes show cdb_valid=0 next cycle, and ptr holds. Squash has priority over arbitration.
- Reset mid-operation: same as squash, plus ptr returns to 0. Reset has priority over squash.
- Simultaneity: all sources requesting with NUM_CDB lanes grants exactly NUM_CDB sources. Requests never exceed the lane count if NUM_CDB >= NUM_SRC.
- Pointer wrap-around: the scan wraps modulo NUM_SRC; no width overflow is allowed in the pointer arithmetic.
- No internal buffering: an ungranted request is the source's responsibility to hold.

Test Plan:
- Reset, then no requests:
  - Hold reset 2 cycles; all outputs 0 and ptr 0.
  - Drive no valid for 3 cycles; cdb_valid stays 00.
- RR_EN=1, NUM_SRC=4, NUM_CDB=2, all four valid and held:
  - Cycle 1: ready = 0011, next cycle lanes = src0 (lane0), src1 (lane1).
  - Cycle 2: ready = 1100, lanes = src2, src3.
  - Cycle 3: ready = 0011 again.
- Single requester src2:
  - value 32'hdeadbeef, prf 6'd17, rob 5'd9, wb=1.
  - Next cycle lane0: valid=1, wb_valid=1, value deadbeef, prf 17, rob 9, src_sel 0100; lane1 invalid.
- Completion-only request (branch):
  - src3 valid with wb=0, PC 32'h0000_1040.
  - Next cycle lane0: cdb_valid=1, cdb_wb_valid=0, cdb_PC 1040.
- Squash:
  - All sources valid with squash=1: src_ready = 0000, next cycle cdb_valid = 00, ptr unchanged.
  - Deassert squash: grants resume from the same ptr.
- Fixed priority (RR_EN=0):
  - src1 and src3 held valid for 3 cycles with NUM_CDB=1.
  - src1 is granted every cycle and src3 is never granted; ready for src3 stays 0.

Source files
------------

// File: rtl/cdb_multi.sv
// Multi-lane common data bus: arbitrates completing execution units onto
// NUM_CDB registered broadcast lanes with a valid/ready handshake.
module cdb_multi #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PRF_LEN = 6,
  parameter int unsigned ROB_LEN = 5,
  parameter int unsigned RR_EN   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC-1:0]           src_wb,
  input  logic [NUM_SRC*XLEN-1:0]      src_value,
  input  logic [NUM_SRC*PRF_LEN-1:0]   src_prf_idx,
  input  logic [NUM_SRC*ROB_LEN-1:0]   src_rob_idx,
  input  logic [NUM_SRC*XLEN-1:0]      src_PC,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic [NUM_CDB-1:0]           cdb_valid,
  output logic [NUM_CDB-1:0]           cdb_wb_valid,
  output logic [NUM_CDB*XLEN-1:0]      cdb_value,
  output logic [NUM_CDB*PRF_LEN-1:0]   cdb_prf_idx,
  output logic [NUM_CDB*ROB_LEN-1:0]   cdb_rob_idx,
  output logic [NUM_CDB*XLEN-1:0]      cdb_PC,
  output logic [NUM_CDB*NUM_SRC-1:0]   cdb_src_sel
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PTR_W-1:0]           r_ptr;
  logic [PTR_W-1:0]           w_ptr_nxt;
  logic [NUM_SRC-1:0]         w_grant;
  logic [NUM_CDB*NUM_SRC-1:0] w_sel;
  logic                       w_any;
  int unsigned                w_idx;
  int unsigned                w_cnt;
  int unsigned                w_last;
  int unsigned                w_last_inc;

  logic [NUM_CDB-1:0]         w_nxt_valid;
  logic [NUM_CDB-1:0]         w_nxt_wb;
  logic [NUM_CDB*XLEN-1:0]    w_nxt_value;
  logic [NUM_CDB*PRF_LEN-1:0] w_nxt_prf;
  logic [NUM_CDB*ROB_LEN-1:0] w_nxt_rob;
  logic [NUM_CDB*XLEN-1:0]    w_nxt_pc;

  // Rotating scan from r_ptr: first NUM_CDB requesters fill lanes 0.. in order
  always_comb begin
    w_grant    = '0;
    w_sel      = '0;
    w_any      = 1'b0;
    w_idx      = 0;
    w_cnt      = 0;
    w_last     = 0;
    w_last_inc = 0;
    w_ptr_nxt  = r_ptr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NUM_SRC) begin
        w_idx = w_idx - NUM_SRC;
      end
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if ((j == w_idx) && src_valid[j] && (w_cnt < NUM_CDB)) begin
          w_grant[j] = 1'b1;
          for (int unsigned l = 0; l < NUM_CDB; l++) begin
            if (l == w_cnt) begin
              w_sel[l*NUM_SRC + j] = 1'b1;
            end
          end
          w_cnt  = w_cnt + 1;
          w_last = j;
          w_any  = 1'b1;
        end
      end
    end
    // Pointer moves just past the last winner, wrapping without overflow
    w_last_inc = w_last + 1;
    if (w_last_inc >= NUM_SRC) begin
      w_last_inc = 0;
    end
    if (w_any) begin
      w_ptr_nxt = PTR_W'(w_last_inc);
    end
  end

  // AND-OR payload mux from each lane's one-hot source select
  always_comb begin
    w_nxt_valid = '0;
    w_nxt_wb    = '0;
    w_nxt_value = '0;
    w_nxt_prf   = '0;
    w_nxt_rob   = '0;
    w_nxt_pc    = '0;
    for (int unsigned l = 0; l < NUM_CDB; l++) begin
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (w_sel[l*NUM_SRC + j]) begin
          w_nxt_valid[l]                  = 1'b1;
          w_nxt_wb[l]                     = w_nxt_wb[l] | src_wb[j];
          w_nxt_value[l*XLEN +: XLEN]     = w_nxt_value[l*XLEN +: XLEN] | src_value[j*XLEN +: XLEN];
          w_nxt_prf[l*PRF_LEN +: PRF_LEN] = w_nxt_prf[l*PRF_LEN +: PRF_LEN] | src_prf_idx[j*PRF_LEN +: PRF_LEN];
          w_nxt_rob[l*ROB_LEN +: ROB_LEN] = w_nxt_rob[l*ROB_LEN +: ROB_LEN] | src_rob_idx[j*ROB_LEN +: ROB_LEN];
          w_nxt_pc[l*XLEN +: XLEN]        = w_nxt_pc[l*XLEN +: XLEN] | src_PC[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Grants are suppressed during a squash so sources keep holding their results
  assign src_ready = w_grant & {NUM_SRC{~squash}};

  // Lane registers and round-robin pointer; reset beats squash beats arbitration
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid    <= '0;
      cdb_wb_valid <= '0;
      cdb_value    <= '0;
      cdb_prf_idx  <= '0;
      cdb_rob_idx  <= '0;
      cdb_PC       <= '0;
      cdb_src_sel  <= '0;
      r_ptr        <= '0;
    end else if (squash) begin
      cdb_valid    <= '0;
      cdb_wb_valid <= '0;
      cdb_value    <= '0;
      cdb_prf_idx  <= '0;
      cdb_rob_idx  <= '0;
      cdb_PC       <= '0;
      cdb_src_sel  <= '0;
    end else begin
      cdb_valid    <= w_nxt_valid;
      cdb_wb_valid <= w_nxt_wb;
      cdb_value    <= w_nxt_value;
      cdb_prf_idx  <= w_nxt_prf;
      cdb_rob_idx  <= w_nxt_rob;
      cdb_PC       <= w_nxt_pc;
      cdb_src_sel  <= w_sel;
      if ((RR_EN != 0) && w_any) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule
